// File: rtl/data_ram_ctrl_pkg.sv
// Shared constants and FSM state type for the data-memory responder.
// Imported by the controller and its RAM array.
package data_ram_ctrl_pkg;

   localparam int unsigned DATA_MEM_NUM      = 1024;
   localparam int unsigned DATA_MEM_NUM_LOG2 = 10;
   localparam int unsigned DATA_BUS          = 32;
   localparam int unsigned BYTE_WIDTH        = 8;
   localparam int unsigned BYTE_LANES        = DATA_BUS / BYTE_WIDTH;

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic WRITE_ENABLE = 1'b1;
   localparam logic RST_ENABLE   = 1'b1;

   typedef enum logic [1:0] {
      DRAM_IDLE = 2'b00,
      DRAM_BUSY = 2'b01,
      DRAM_DONE = 2'b10
   } dram_state_e;

endpackage

// File: rtl/data_ram_array.sv
// Synchronous 1R/1W word RAM with per-byte write mask and registered read.
// Contents are not reset.
module data_ram_array
   import data_ram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DATA_MEM_NUM_LOG2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [BYTE_LANES-1:0] be,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_BUS-1:0]   wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_BUS-1:0]   rdata
);

   logic [DATA_BUS-1:0] mem [1 << ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we == WRITE_ENABLE) begin
         for (int unsigned k = 0; k < BYTE_LANES; k++) begin
            if (be[k]) mem[waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/data_ram_ctrl.sv
// MEM-stage data-memory responder: wait-state FSM in front of a byte-writable RAM,
// with combinational stall request until the access is acknowledged.
module data_ram_ctrl
   import data_ram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DATA_MEM_NUM_LOG2,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        stall_req_o
);

   localparam int unsigned CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   dram_state_e state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic                  lat_we;
   logic [3:0]            lat_sel;
   logic [ADDR_WIDTH-1:0] lat_word;
   logic [31:0]           lat_data;
   logic                  lat_err;

   logic                  acc_we;
   logic [3:0]            acc_sel;
   logic [ADDR_WIDTH-1:0] acc_word;
   logic [31:0]           acc_data;
   logic                  acc_err;

   logic        req_err;
   logic        enter_done;
   logic        rd_valid;
   logic [31:0] ram_q;
   logic        unused_addr_lsb;

   assign req_err         = |addr_i[31:ADDR_WIDTH+2];
   assign unused_addr_lsb = ^addr_i[1:0];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         DRAM_IDLE: begin
            if (ce_i == CHIP_ENABLE) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = DRAM_DONE;
               end else begin
                  cnt_nxt   = CNT_LOAD;
                  state_nxt = DRAM_BUSY;
               end
            end
         end
         DRAM_BUSY: begin
            if (ce_i != CHIP_ENABLE) state_nxt = DRAM_IDLE;
            else if (cnt == CNT_ONE) state_nxt = DRAM_DONE;
            else                     cnt_nxt   = cnt - CNT_ONE;
         end
         DRAM_DONE: state_nxt = DRAM_IDLE;
         default:   state_nxt = DRAM_IDLE;
      endcase
   end

   // With zero wait states DONE is entered straight from IDLE, so the RAM
   // must see the live request rather than the latched copy.
   always_comb begin
      if (state == DRAM_IDLE) begin
         acc_we   = we_i;
         acc_sel  = sel_i;
         acc_word = addr_i[ADDR_WIDTH+1:2];
         acc_data = data_i;
         acc_err  = req_err;
      end else begin
         acc_we   = lat_we;
         acc_sel  = lat_sel;
         acc_word = lat_word;
         acc_data = lat_data;
         acc_err  = lat_err;
      end
   end

   assign enter_done = (state_nxt == DRAM_DONE) && (rst != RST_ENABLE);

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state    <= DRAM_IDLE;
         cnt      <= '0;
         err_o    <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (enter_done) begin
            err_o    <= acc_err;
            rd_valid <= ~acc_we & ~acc_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == DRAM_IDLE && ce_i == CHIP_ENABLE) begin
         lat_we   <= we_i;
         lat_sel  <= sel_i;
         lat_word <= addr_i[ADDR_WIDTH+1:2];
         lat_data <= data_i;
         lat_err  <= req_err;
      end
   end

   data_ram_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk  (clk),
      .we   (enter_done & acc_we & ~acc_err),
      .be   (acc_sel),
      .waddr(acc_word),
      .wdata(acc_data),
      .re   (enter_done & ~acc_we & ~acc_err),
      .raddr(acc_word),
      .rdata(ram_q)
   );

   // Array read register holds across idle cycles; the flag masks it to zero
   // after writes, out-of-range accesses and reset.
   assign data_o      = rd_valid ? ram_q : '0;
   assign ack_o       = (state == DRAM_DONE);
   assign stall_req_o = ce_i & ~ack_o;

endmodule
